// File: rtl/resp_router_pkg.sv
// Shared definitions for the response router: error-flag bit positions and a one-hot test.
// No logic state; combinational helpers only.
package resp_router_pkg;

    localparam int ERR_OVF     = 0;
    localparam int ERR_ORPHAN  = 1;
    localparam int ERR_ONEHOT  = 2;
    localparam int ERR_W       = 3;

    // Grant vectors up to this width are checked; narrower vectors are zero-extended by the caller.
    localparam int ONEHOT_MAXW = 32;

    function automatic logic is_onehot(input logic [ONEHOT_MAXW-1:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < ONEHOT_MAXW; i++) begin
            ones += int'(v[i]);
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order tag store: DEPTH entries of WIDTH bits, pointer/count based, no bypass.
// Latency: a pushed entry is visible at head one cycle later. A push while full and a pop while empty are ignored.
module tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    // Full is decoded from the registered count only, so a same-cycle pop never frees a slot early.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/resp_router.sv
// Routes in-order downstream responses back to the requester whose grant issued the request.
// Latency: combinational from rsp_valid to out_valid; a tag is routable the cycle after its push. Stalls upstream when DEPTH tags are outstanding.
module resp_router
    import resp_router_pkg::*;
#(
    parameter int N     = 2,
    parameter int DEPTH = 4,
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     req_grant,
    input  logic             req_fire,
    output logic             req_stall,
    input  logic             rsp_valid,
    input  logic [NBITS-1:0] rsp_data,
    output logic             rsp_ready,
    output logic [N-1:0]     out_valid,
    output logic [NBITS-1:0] out_data,
    input  logic [N-1:0]     out_ready,
    output logic [ERR_W-1:0] err
);

    logic [N-1:0]     head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [ERR_W-1:0] err_q;

    tag_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .push_dat (req_grant),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    assign req_stall = fifo_full;
    assign push      = req_fire && !req_stall;

    // Head is all-zero when empty, so an orphan response never sees ready or a valid.
    assign out_valid = head & {N{rsp_valid}};
    assign out_data  = rsp_data;
    assign rsp_ready = |(head & out_ready);
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= '0;
        end else begin
            if (req_fire && req_stall) begin
                err_q[ERR_OVF] <= 1'b1;
            end
            if (rsp_valid && fifo_empty) begin
                err_q[ERR_ORPHAN] <= 1'b1;
            end
            if (req_fire && !is_onehot(ONEHOT_MAXW'(req_grant))) begin
                err_q[ERR_ONEHOT] <= 1'b1;
            end
        end
    end

    assign err = err_q;

endmodule
